pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges four stall/flush sources into one set of pipeline-register write enables, flushes and the bubble select:
  - load-use hazard request
  - taken branch in EX
  - multi-cycle mul/div occupying EX
  - data-memory wait in MEM
- Owns the mul/div occupancy counter and a memory-wait watchdog.
- Sits beside the hazard detection unit and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- MULDIV_LATENCY, 4, total cycles a mul/div instruction occupies EX; legal range 1..63.
- MEM_TIMEOUT, 15, consecutive memory-wait cycles before the timeout error is flagged; legal range 1..255.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- load_use_hazard  in  1  load-use stall request from hazard detection.
- branch_taken_ex  in  1  branch/jump resolved taken in EX.
- muldiv_start  in  1  ID/EX holds a mul/div instruction; high for as long as it is in EX.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Write  out  1  ID/EX register enable.
- EX_MEM_Write  out  1  EX/MEM register enable.
- MEM_WB_Write  out  1  MEM/WB register enable.
- ControlSignalSelector  out  1  1 = zero the control bits entering ID/EX (bubble).
- EX_MEM_Bubble  out  1  1 = load a NOP into EX/MEM.
- IF_ID_Flush  out  1  clear IF/ID.
- ID_EX_Flush  out  1  clear ID/EX.
- muldiv_busy  out  1  mul/div occupancy in progress.
- muldiv_done  out  1  mul/div result valid; EX advances this cycle.
- dmem_timeout  out  1  sticky watchdog error.
- stall_count  out  32  stall-cycle count (see Optional Feature).
- flush_count  out  32  flush-event count (see Optional Feature).

Behaviour:
- Outputs are combinational from state, counters and inputs (Mealy).
- State, counters and flags are registered on posedge clk and reset asynchronously by rst.
- Default (no condition active): all *_Write = 1; all flushes, bubbles and ControlSignalSelector = 0.
- During rst: FSM = RUN, mul/div counter = 0, wait counter = 0, done flag = 0, dmem_timeout = 0, counters = 0.
- During rst, all outputs are forced as follows:
  - all *_Write = 0
  - all flushes, bubbles and ControlSignalSelector = 0
  - muldiv_busy = 0, muldiv_done = 0
- mem_stall = dmem_req & ~dmem_ready. It has highest priority in every state:
  - all five *_Write = 0; all flushes and bubbles = 0
  - FSM state, mul/div counter and done flag hold
  - wait counter increments, saturating at MEM_TIMEOUT
  - when the wait counter reaches MEM_TIMEOUT, set dmem_timeout; it stays set until rst
  - wait counter clears on any cycle without mem_stall
- FSM states: RUN, MULDIV. Without mem_stall, priority in RUN is:
  1. muldiv_start & ~done_flag & MULDIV_LATENCY > 1:
     - PCWrite = IF_ID_Write = ID_EX_Write = 0; EX_MEM_Bubble = 1; muldiv_busy = 1
     - if MULDIV_LATENCY == 2: set done_flag, stay in RUN
     - otherwise: counter <= MULDIV_LATENCY-2, go to MULDIV
  2. muldiv_start & (done_flag | MULDIV_LATENCY == 1):
     - muldiv_done = 1; normal enables; done_flag clears
  3. branch_taken_ex:
     - IF_ID_Flush = 1, ID_EX_Flush = 1; PCWrite = 1 (redirect)
     - any load_use_hazard in the same cycle is ignored
  4. load_use_hazard:
     - PCWrite = 0, IF_ID_Write = 0, ControlSignalSelector = 1; ID_EX_Write = 1
- MULDIV state:
  - same freeze as priority 1; counter decrements each cycle
  - when counter == 1: set done_flag, go to RUN
  - all other requests are ignored while in MULDIV
- Resulting occupancy: EX occupancy is exactly MULDIV_LATENCY cycles. The freeze lasts MULDIV_LATENCY-1 cycles, not counting mem_stall cycles.
- Asserting muldiv_start and branch_taken_ex together is illegal: muldiv wins, and an assertion flags it in simulation.
- rst asserted mid-MULDIV aborts to RUN immediately.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - stall_count increments on every cycle with PCWrite = 0 outside reset.
  - flush_count increments on every cycle with IF_ID_Flush = 1.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package holds:
  - FSM state encoding (RUN = 0, MULDIV = 1)
  - counter widths derived from the parameter ranges (6-bit mul/div counter, 8-bit wait counter)
  - bit-position constants of the control bundle zeroed by ControlSignalSelector
- One natural sub-module: stall_watchdog, containing the wait counter and sticky dmem_timeout.

Test Plan:
- Load-use only: load_use_hazard = 1 for 1 cycle -> PCWrite = 0, IF_ID_Write = 0, ControlSignalSelector = 1 for exactly that cycle; next cycle all defaults.
- MULDIV_LATENCY = 4, muldiv_start held high -> PCWrite = 0 and EX_MEM_Bubble = 1 for 3 cycles; muldiv_done = 1 on the 4th cycle; no restart on the 5th.
- branch_taken_ex = 1 with load_use_hazard = 1 -> IF_ID_Flush = 1, ID_EX_Flush = 1, PCWrite = 1, ControlSignalSelector = 0.
- dmem_req = 1, dmem_ready = 0 for 2 cycles inside MULDIV (latency 4):
  - all *_Write = 0 in those cycles
  - muldiv_done arrives 2 cycles later than without the stall
- dmem_req = 1, dmem_ready = 0 for 15 cycles -> dmem_timeout rises on cycle 15 and stays high after dmem_ready; clears only on rst.
- rst asserted in the 2nd MULDIV cycle -> all outputs at reset values immediately. After release, muldiv_start = 1 -> a full MULDIV_LATENCY-cycle sequence restarts.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and widths for the pipeline stall/flush sequencer.
// Used by pipeline_stall_controller and stall_watchdog.
package pipeline_stall_controller_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_t;

    // Sized for MULDIV_LATENCY up to 63 and MEM_TIMEOUT up to 255.
    localparam int MULDIV_CNT_W = 6;
    localparam int WAIT_CNT_W   = 8;

    // Bit positions of the ID/EX control bundle cleared by ControlSignalSelector.
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 6;
    localparam int CTRL_ALU_OP_LO  = 7;
    localparam int CTRL_ALU_OP_HI  = 8;
    localparam int CTRL_W          = 9;

endpackage

// File: rtl/pipeline_stall_controller_watchdog.sv
// stall_watchdog: counts consecutive data-memory wait cycles and raises a
// sticky timeout flag once MEM_TIMEOUT consecutive waits have elapsed.
module stall_watchdog
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_stall,
    output logic dmem_timeout
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_next;

    assign wait_next = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt     <= '0;
            dmem_timeout <= 1'b0;
        end else if (mem_stall) begin
            wait_cnt <= wait_next;
            if (wait_next == LIMIT)
                dmem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch,
// mul/div occupancy and memory wait. Optional perf counters: STALL_PERF_CNT_EN.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int MEM_TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use_hazard,
    input  logic        branch_taken_ex,
    input  logic        muldiv_start,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        EX_MEM_Write,
    output logic        MEM_WB_Write,
    output logic        ControlSignalSelector,
    output logic        EX_MEM_Bubble,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic        dmem_timeout,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    localparam logic MULTI_CYCLE = (MULDIV_LATENCY > 1);
    localparam logic SINGLE_CYC  = (MULDIV_LATENCY == 1);
    localparam logic TWO_CYC     = (MULDIV_LATENCY == 2);
    localparam logic [MULDIV_CNT_W-1:0] MCNT_LOAD = MULDIV_CNT_W'(MULDIV_LATENCY - 2);

    state_t                  state;
    logic [MULDIV_CNT_W-1:0] mcnt;
    logic                    done_flag;
    logic                    mem_stall;
    logic                    start_multi;
    logic                    finish_now;

    assign mem_stall   = dmem_req & ~dmem_ready;
    assign start_multi = muldiv_start & ~done_flag & MULTI_CYCLE;
    assign finish_now  = muldiv_start & (done_flag | SINGLE_CYC);

    always_comb begin
        PCWrite               = 1'b1;
        IF_ID_Write           = 1'b1;
        ID_EX_Write           = 1'b1;
        EX_MEM_Write          = 1'b1;
        MEM_WB_Write          = 1'b1;
        ControlSignalSelector = 1'b0;
        EX_MEM_Bubble         = 1'b0;
        IF_ID_Flush           = 1'b0;
        ID_EX_Flush           = 1'b0;
        muldiv_busy           = 1'b0;
        muldiv_done           = 1'b0;
        if (rst) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end else if (mem_stall) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
            muldiv_busy  = (state == MULDIV);
        end else if (state == MULDIV || start_multi) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            muldiv_busy   = 1'b1;
        end else if (finish_now) begin
            muldiv_done = 1'b1;
        end else if (branch_taken_ex) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (load_use_hazard) begin
            PCWrite               = 1'b0;
            IF_ID_Write           = 1'b0;
            ControlSignalSelector = 1'b1;
        end
    end

    // A memory wait freezes the sequencer entirely, so the freeze stretches by the wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            mcnt      <= '0;
            done_flag <= 1'b0;
        end else if (!mem_stall) begin
            case (state)
                RUN: begin
                    if (start_multi) begin
                        if (TWO_CYC) begin
                            done_flag <= 1'b1;
                        end else begin
                            mcnt  <= MCNT_LOAD;
                            state <= MULDIV;
                        end
                    end else if (finish_now) begin
                        done_flag <= 1'b0;
                    end
                end
                MULDIV: begin
                    if (mcnt == MULDIV_CNT_W'(1)) begin
                        done_flag <= 1'b1;
                        state     <= RUN;
                    end
                    mcnt <= mcnt - 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    stall_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .mem_stall    (mem_stall),
        .dmem_timeout (dmem_timeout)
    );

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!PCWrite)
                stall_count <= stall_count + 32'd1;
            if (IF_ID_Flush)
                flush_count <= flush_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

    a_no_muldiv_with_branch: assert property (
        @(posedge clk) disable iff (rst) !(muldiv_start && branch_taken_ex)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MULDIV_LATENCY=4, MEM_TIMEOUT=15).
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use_hazard, branch_taken_ex, muldiv_start, dmem_req, dmem_ready;
    logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
    logic        ControlSignalSelector, EX_MEM_Bubble, IF_ID_Flush, ID_EX_Flush;
    logic        muldiv_busy, muldiv_done, dmem_timeout;
    logic [31:0] stall_count, flush_count;

    int n_checks = 0;
    int n_errors = 0;

    // {PC, IFID, IDEX, EXMEM, MEMWB, CSS, Bubble, IFIDFlush, IDEXFlush, busy, done}
    localparam logic [10:0] O_RST  = 11'b00000_00000_0;
    localparam logic [10:0] O_DEF  = 11'b11111_00000_0;
    localparam logic [10:0] O_LU   = 11'b00111_10000_0;
    localparam logic [10:0] O_BR   = 11'b11111_00110_0;
    localparam logic [10:0] O_FRZ  = 11'b00011_01001_0;
    localparam logic [10:0] O_DONE = 11'b11111_00000_1;
    localparam logic [10:0] O_MSR  = 11'b00000_00000_0;
    localparam logic [10:0] O_MSM  = 11'b00000_00001_0;

    pipeline_stall_controller #(
        .MULDIV_LATENCY (4),
        .MEM_TIMEOUT    (15)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .load_use_hazard       (load_use_hazard),
        .branch_taken_ex       (branch_taken_ex),
        .muldiv_start          (muldiv_start),
        .dmem_req              (dmem_req),
        .dmem_ready            (dmem_ready),
        .PCWrite               (PCWrite),
        .IF_ID_Write           (IF_ID_Write),
        .ID_EX_Write           (ID_EX_Write),
        .EX_MEM_Write          (EX_MEM_Write),
        .MEM_WB_Write          (MEM_WB_Write),
        .ControlSignalSelector (ControlSignalSelector),
        .EX_MEM_Bubble         (EX_MEM_Bubble),
        .IF_ID_Flush           (IF_ID_Flush),
        .ID_EX_Flush           (ID_EX_Flush),
        .muldiv_busy           (muldiv_busy),
        .muldiv_done           (muldiv_done),
        .dmem_timeout          (dmem_timeout),
        .stall_count           (stall_count),
        .flush_count           (flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
                ControlSignalSelector, EX_MEM_Bubble, IF_ID_Flush, ID_EX_Flush,
                muldiv_busy, muldiv_done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        load_use_hazard = 1'b0; branch_taken_ex = 1'b0; muldiv_start = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
        settle();
        chk("reset_outs", 32'(outs()), 32'(O_RST));
        chk("reset_timeout", 32'(dmem_timeout), 32'd0);
        chk("reset_stall_count", stall_count, 32'd0);
        chk("reset_flush_count", flush_count, 32'd0);
        cyc(); cyc();
        rst = 1'b0;
        settle();
        chk("idle_default", 32'(outs()), 32'(O_DEF));

        // load-use for exactly one cycle
        cyc(); load_use_hazard = 1'b1; settle();
        chk("load_use", 32'(outs()), 32'(O_LU));
        cyc(); load_use_hazard = 1'b0; settle();
        chk("load_use_after", 32'(outs()), 32'(O_DEF));

        // branch overrides load-use
        cyc(); branch_taken_ex = 1'b1; load_use_hazard = 1'b1; settle();
        chk("branch_with_lu", 32'(outs()), 32'(O_BR));
        cyc(); branch_taken_ex = 1'b0; load_use_hazard = 1'b0; settle();
        chk("branch_after", 32'(outs()), 32'(O_DEF));

        // mul/div, latency 4: three freeze cycles then done
        cyc(); muldiv_start = 1'b1; settle();
        chk("md_c1", 32'(outs()), 32'(O_FRZ));
        cyc(); chk("md_c2", 32'(outs()), 32'(O_FRZ));
        cyc(); chk("md_c3", 32'(outs()), 32'(O_FRZ));
        cyc(); chk("md_c4_done", 32'(outs()), 32'(O_DONE));
        cyc(); muldiv_start = 1'b0; settle();
        chk("md_c5_no_restart", 32'(outs()), 32'(O_DEF));

        // mul/div with two memory-wait cycles inside MULDIV
        cyc(); muldiv_start = 1'b1; settle();
        chk("mdw_c1", 32'(outs()), 32'(O_FRZ));
        cyc(); dmem_req = 1'b1; dmem_ready = 1'b0; settle();
        chk("mdw_stall1", 32'(outs()), 32'(O_MSM));
        cyc(); chk("mdw_stall2", 32'(outs()), 32'(O_MSM));
        cyc(); dmem_req = 1'b0; settle();
        chk("mdw_c2", 32'(outs()), 32'(O_FRZ));
        cyc(); chk("mdw_c3", 32'(outs()), 32'(O_FRZ));
        cyc(); chk("mdw_done", 32'(outs()), 32'(O_DONE));
        chk("mdw_no_timeout", 32'(dmem_timeout), 32'd0);
        cyc(); muldiv_start = 1'b0; settle();
        chk("mdw_after", 32'(outs()), 32'(O_DEF));

        // watchdog: 15 consecutive waits
        cyc(); dmem_req = 1'b1; dmem_ready = 1'b0; settle();
        chk("wd_stall_outs", 32'(outs()), 32'(O_MSR));
        for (int i = 0; i < 14; i++) cyc();
        chk("wd_before_limit", 32'(dmem_timeout), 32'd0);
        cyc();
        chk("wd_at_limit", 32'(dmem_timeout), 32'd1);
        dmem_ready = 1'b1; settle();
        chk("wd_ready_outs", 32'(outs()), 32'(O_DEF));
        cyc(); dmem_req = 1'b0; dmem_ready = 1'b0; cyc();
        chk("wd_sticky", 32'(dmem_timeout), 32'd1);

        // reset in the second MULDIV cycle
        muldiv_start = 1'b1; settle();
        chk("rmd_c1", 32'(outs()), 32'(O_FRZ));
        cyc(); rst = 1'b1; settle();
        chk("rmd_reset_outs", 32'(outs()), 32'(O_RST));
        chk("rmd_reset_timeout", 32'(dmem_timeout), 32'd0);
        cyc(); rst = 1'b0; settle();
        chk("rmd_restart_c1", 32'(outs()), 32'(O_FRZ));
        cyc(); chk("rmd_restart_c2", 32'(outs()), 32'(O_FRZ));
        cyc(); chk("rmd_restart_c3", 32'(outs()), 32'(O_FRZ));
        cyc(); chk("rmd_restart_done", 32'(outs()), 32'(O_DONE));
        cyc(); muldiv_start = 1'b0; settle();
        chk("rmd_after", 32'(outs()), 32'(O_DEF));
`ifndef STALL_PERF_CNT_EN
        chk("perf_stall_tied", stall_count, 32'd0);
        chk("perf_flush_tied", flush_count, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
